// File: rtl/lcd_pkg.sv
// Shared LCD frame-buffer geometry, sampling window constants and sampler FSM encoding.
package lcd_pkg;
   localparam int         COL_NUM   = 320;
   localparam int         ROW_NUM   = 240;
   localparam logic [16:0] PIXEL_NUM = 17'd76800;

   localparam int         WIN_X0    = 48;
   localparam int         WIN_Y0    = 8;
   localparam int         SCALE     = 8;
   localparam int         OUT_DIM   = 28;
   localparam int         WIN_DIM   = SCALE * OUT_DIM;
   localparam logic [6:0] THRESHOLD = 7'd16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Frame-buffer address of window pixel (col, brow*SCALE + row).
   function automatic logic [16:0] win_addr(input logic [4:0] brow,
                                            input logic [2:0] row,
                                            input logic [7:0] col);
      logic [16:0] y;
      y = 17'(WIN_Y0) + 17'(brow) * 17'(SCALE) + 17'(row);
      return y * 17'(COL_NUM) + 17'(WIN_X0) + 17'(col);
   endfunction
endpackage

// File: rtl/frame_sampler_counter.sv
// Enabled up-counter that wraps to zero after MAX_VALUE; asynchronous active-low clear.
module counter #(
   parameter int MAX_VALUE = 7,
   parameter int W         = $clog2(MAX_VALUE + 1)
) (
   input  logic         clk,
   input  logic         en,
   input  logic         reset,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (en)
         count <= (count == W'(MAX_VALUE)) ? '0 : count + 1'b1;
   end
endmodule

// File: rtl/frame_sampler.sv
// Reduces a 224x224 window of the 1-bit LCD frame buffer to 28x28 white-pixel counts.
// Optional build macro FRAME_SAMPLER_THRESHOLD_EN binarises each output to 0 or 64.
module frame_sampler
   import lcd_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        start,
   output logic [16:0] ram_read_addr,
   input  logic        ram_q,
   output logic        pix_valid,
   output logic [6:0]  pix_data,
   output logic [9:0]  pix_idx,
   input  logic        pix_ready,
   output logic        busy,
   output logic        done
);
   state_t      state;
   logic [7:0]  col;
   logic [2:0]  row;
   logic [4:0]  bcol;
   logic [4:0]  brow;
   logic [7:0]  col_d_p1;
   logic        vld_p1;
   logic [6:0]  acc [OUT_DIM];
   logic [6:0]  cur;

   logic in_read, in_emit, accept;
   logic col_en, row_en, last_rd, last_b;

   assign in_read = (state == READ);
   assign in_emit = (state == EMIT);
   assign accept  = en && in_emit && pix_ready;
   assign col_en  = en && in_read;
   assign row_en  = col_en && (col == 8'(WIN_DIM - 1));
   assign last_rd = row_en && (row == 3'(SCALE - 1));
   assign last_b  = accept && (bcol == 5'(OUT_DIM - 1));

   // Counters always wrap back to zero at pass end, so IDLE finds them cleared.
   counter #(.MAX_VALUE(WIN_DIM - 1)) u_col  (.clk(clk), .en(col_en), .reset(reset_n), .count(col));
   counter #(.MAX_VALUE(SCALE - 1))   u_row  (.clk(clk), .en(row_en), .reset(reset_n), .count(row));
   counter #(.MAX_VALUE(OUT_DIM - 1)) u_bcol (.clk(clk), .en(accept), .reset(reset_n), .count(bcol));
   counter #(.MAX_VALUE(OUT_DIM - 1)) u_brow (.clk(clk), .en(last_b), .reset(reset_n), .count(brow));

   always_comb begin
      ram_read_addr = '0;
      if (in_read)
         ram_read_addr = win_addr(brow, row, col);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pix_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= READ;
                  busy  <= 1'b1;
               end
            end
            READ: begin
               if (last_rd)
                  state <= DRAIN;
            end
            DRAIN: begin
               state     <= EMIT;
               pix_valid <= 1'b1;
            end
            EMIT: begin
               if (pix_ready && (bcol == 5'(OUT_DIM - 1))) begin
                  pix_valid <= 1'b0;
                  if (brow == 5'(OUT_DIM - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p1: read-data stage, aligned with the one-cycle frame-buffer latency
   always_ff @(posedge clk) begin
      if (en)
         col_d_p1 <= col;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1 <= 1'b0;
         for (int i = 0; i < OUT_DIM; i++)
            acc[i] <= '0;
      end else if (en) begin
         vld_p1 <= in_read;
         if (state == IDLE) begin
            for (int i = 0; i < OUT_DIM; i++)
               acc[i] <= '0;
         end else if (vld_p1 && ram_q) begin
            acc[col_d_p1[7:3]] <= acc[col_d_p1[7:3]] + 7'd1;
         end
         if (accept)
            acc[bcol] <= '0;
      end
   end

   assign cur     = acc[bcol];
   assign pix_idx = 10'(brow) * 10'(OUT_DIM) + 10'(bcol);

`ifdef FRAME_SAMPLER_THRESHOLD_EN
   assign pix_data = pix_valid ? ((cur >= THRESHOLD) ? 7'd64 : 7'd0) : 7'd0;
`else
   assign pix_data = pix_valid ? cur : 7'd0;
`endif
endmodule

// File: doc/frame_sampler.md
# frame_sampler

Reads the 320x240 1-bit LCD frame buffer written by the drawing logic and reduces a fixed square window to a 28x28 grey-level image for the digit classifier. Each output pixel is the count of white frame-buffer pixels in one 8x8 block. Output pixels are streamed in raster order over a valid/ready handshake. The block is the read-side client of the frame buffer's second port and sits between that port and the classifier input buffer.

## Interface
- PIXEL_NUM, 17'd76800, frame buffer depth
- COL_NUM, 320, frame buffer columns
- WIN_X0, 48, leftmost window column
- WIN_Y0, 8, top window row
- SCALE, 8, block edge in pixels
- OUT_DIM, 28, output image edge; window edge = SCALE*OUT_DIM = 224
- THRESHOLD, 7'd16, binarisation threshold (used only with macro)
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global advance enable; when low, all state and outputs hold
- start  in  1  request one full sampling pass; sampled only in IDLE
- ram_read_addr  out  17  frame buffer read address
- ram_q  in  1  frame buffer read data, valid one cycle after address
- pix_valid  out  1  output pixel valid
- pix_data  out  7  white-pixel count 0..64
- pix_idx  out  10  output index 0..783 = brow*28 + bcol
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready && en
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at pass end

## Operation
- FSM states: IDLE, READ, DRAIN, EMIT, DONE.
- IDLE:
  - start && en -> READ.
  - Clear brow, row, col and the 28 accumulators (7 bits each).
- READ:
  - Issue ram_read_addr = (WIN_Y0 + brow*8 + row)*COL_NUM + WIN_X0 + col, one address per cycle.
  - col runs 0..223, then row runs 0..7.
  - On the cycle after each address, if ram_q = 1, increment accumulator (col_d >> 3). col_d is col delayed one cycle, together with a read-valid flag.
  - After address (row 7, col 223) -> DRAIN.
- DRAIN: one cycle; absorbs the last read datum -> EMIT.
- EMIT:
  - bcol runs 0..27; pix_data = acc[bcol], pix_idx = brow*28 + bcol, pix_valid = 1.
  - On accept: clear acc[bcol], then advance bcol.
  - After bcol 27 is accepted: if brow = 27 -> DONE; else brow++ -> READ.
- DONE: done = 1 for one cycle -> IDLE.
- Boundaries:
  - Accumulator saturation is impossible (max 64 fits in 7 bits).
  - start while busy is ignored.
  - en low freezes the FSM, counters and read pipeline. An outstanding ram_q is not captured until en is high again; the frame buffer must hold its data output while en is low.
  - pix_ready low in EMIT holds pix_valid, pix_data and pix_idx stable.
  - Reset asserted mid-pass: immediate return to IDLE, partial image discarded, no done.
- Address arithmetic is 17-bit unsigned. The window is fully inside the frame by parameter choice; no bounds check in RTL.

## Timing
- Reset values:
  - Sreg = IDLE.
  - ram_read_addr = 0, pix_valid = 0, pix_data = 0, pix_idx = 0, busy = 0, done = 0.
  - All accumulators = 0.
- ram_read_addr is driven only in READ; it is 0 in all other states.
- Read latency is one cycle; no additional pipeline stage.
- With en and pix_ready held high, one pass is 28*(1792 + 1 + 28) + 1 = 50989 cycles from leaving IDLE to the done cycle inclusive.
  - 1792 = READ cycles per block-row, 1 = DRAIN, 28 = EMIT.
- First pix_valid appears 1793 cycles after entering READ.

## Configuration
- FRAME_SAMPLER_THRESHOLD_EN defined: pix_data = (acc >= THRESHOLD) ? 7'd64 : 7'd0, giving binary output with the same width.
- Not defined: pix_data = raw count.
- Timing is identical in both builds.

## Structure
- Shared package `lcd_pkg` holds:
  - COL_NUM, ROW_NUM and PIXEL_NUM constants.
  - Window and scale constants.
  - FSM state encoding localparams.
- One sub-module, `counter` (existing: clk, en, reset, count, MAX_VALUE), instantiated for col, row, bcol and brow.
- Accumulators stay as an array in the top module.

## Test plan
- All-zero frame, start pulse, pix_ready = 1 -> 784 beats, all pix_data = 0, pix_idx 0..783 in order, done once at cycle 50989.
- All-ones frame -> every pix_data = 64.
- Single white pixel at (x=48+8*5+3, y=8+8*2+7) -> only pix_idx 61 has pix_data = 1.
- pix_ready toggled randomly -> output sequence identical to the ready=1 run; data and index stable while stalled.
- start re-pulsed mid-pass, then reset_n pulsed low in READ -> start ignored; after reset, busy = 0, pix_valid = 0, no done; a fresh pass completes correctly.
- With FRAME_SAMPLER_THRESHOLD_EN, block count 16 -> 64 and block count 15 -> 0.
